// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the pipeline/core side (drives hazard info, consumes controls).
// slave : the hazard controller (consumes hazard info, drives controls).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // Hazard / debug information from the core
  logic [4:0]       ID_RS;
  logic [4:0]       ID_RT;
  logic             ID_use_rt;
  logic             DX_MemRead;
  logic [4:0]       DX_RD;
  logic             XM_branch;
  logic [31:0]      XM_BT;
  logic             dbg_halt;
  logic             dbg_step;
  logic             cnt_clr;
  // Pipeline register controls and status back to the core
  logic             PC_write;
  logic             PC_sel;
  logic [31:0]      PC_target;
  logic             IF_ID_write;
  logic             IF_flush;
  logic             DX_bubble;
  logic             XM_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ID_RS, ID_RT, ID_use_rt, DX_MemRead, DX_RD, XM_branch, XM_BT,
           dbg_halt, dbg_step, cnt_clr,
    input  PC_write, PC_sel, PC_target, IF_ID_write, IF_flush, DX_bubble,
           XM_flush, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ID_RS, ID_RT, ID_use_rt, DX_MemRead, DX_RD, XM_branch, XM_BT,
           dbg_halt, dbg_step, cnt_clr,
    output PC_write, PC_sel, PC_target, IF_ID_write, IF_flush, DX_bubble,
           XM_flush, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stall,
// taken-branch redirect/squash, and debug drain/halt/single-step.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-high
//   bus  - hazard_ctrl_if.slave (hazard inputs in, pipeline controls out)
// State, drain count, halted and the two event counters are registered;
// the pipeline controls are decoded combinationally from state + inputs.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_drain;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic   w_load_use;
  logic   w_branch;
  state_t w_dec_state;

  // Load in EX writing a register the ID instruction reads ($0 never hazards)
  assign w_load_use = bus.DX_MemRead && (bus.DX_RD != 5'd0) &&
                      ((bus.DX_RD == bus.ID_RS) ||
                       (bus.ID_use_rt && (bus.DX_RD == bus.ID_RT)));
  assign w_branch   = bus.XM_branch;

  // While reset is held the controls decode as RUN
  assign w_dec_state = rst ? S_RUN : r_state;

  // Control decode: branch beats load-use beats the state action
  always_comb begin
    bus.PC_write    = 1'b1;
    bus.IF_ID_write = 1'b1;
    bus.PC_sel      = 1'b0;
    bus.IF_flush    = 1'b0;
    bus.DX_bubble   = 1'b0;
    bus.XM_flush    = 1'b0;
    if (w_branch) begin
      bus.PC_sel    = 1'b1;
      bus.IF_flush  = 1'b1;
      bus.DX_bubble = 1'b1;
      bus.XM_flush  = 1'b1;
    end else if (w_load_use) begin
      bus.PC_write    = 1'b0;
      bus.IF_ID_write = 1'b0;
      bus.DX_bubble   = 1'b1;
    end else if (w_dec_state == S_DRAIN || w_dec_state == S_HALTED) begin
      // PC holds the resume address while bubbles flow down the pipe
      bus.PC_write = 1'b0;
      bus.IF_flush = 1'b1;
    end
  end

  assign bus.PC_target = bus.XM_BT;
  assign bus.halted    = r_halted;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // Sequencer state and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_drain     <= '0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.cnt_clr) begin
        r_stall_cnt <= '0;
        r_flush_cnt <= '0;
      end else if (w_branch) begin
        if (!(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_load_use) begin
        if (!(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      case (r_state)
        S_RUN: begin
          r_halted <= 1'b0;
          if (bus.dbg_halt) begin
            r_state <= S_DRAIN;
            r_drain <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          r_halted <= 1'b0;
          // A redirect refills the pipe, so the drain restarts; a stall
          // cycle injects no extra bubble, so it does not count.
          if (w_branch) begin
            r_drain <= DRAIN_LOAD;
          end else if (!w_load_use) begin
            if (r_drain == '0) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_drain <= r_drain - DW'(1);
            end
          end
        end
        S_HALTED: begin
          if (!bus.dbg_halt) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end else if (bus.dbg_step) begin
            r_state  <= S_STEP;
            r_halted <= 1'b0;
          end
        end
        S_STEP: begin
          r_halted <= 1'b0;
          r_state  <= S_DRAIN;
          r_drain  <= DRAIN_LOAD;
        end
        default: begin
          r_state  <= S_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle hazard vectors in
// RUN plus hand-written drain/halt/step/saturation/reset sequences.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.DRAIN_CYC(4), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ID_RS, ID_RT, ID_use_rt, DX_MemRead, DX_RD, XM_branch, XM_BT} -> expected
  // ctl order: {PC_write, IF_ID_write, PC_sel, IF_flush, DX_bubble, XM_flush}
  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rt;
    logic        memread;
    logic [4:0]  rd;
    logic        br;
    logic [31:0] bt;
    logic [5:0]  ctl;
    int          st_inc;
    int          fl_inc;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    bus.ID_RS      = 5'd0;
    bus.ID_RT      = 5'd0;
    bus.ID_use_rt  = 1'b0;
    bus.DX_MemRead = 1'b0;
    bus.DX_RD      = 5'd0;
    bus.XM_branch  = 1'b0;
    bus.XM_BT      = 32'h0;
  endtask

  function automatic logic [5:0] ctl_now();
    return {bus.PC_write, bus.IF_ID_write, bus.PC_sel,
            bus.IF_flush, bus.DX_bubble, bus.XM_flush};
  endfunction

  initial begin
    int exp_stall;
    int exp_flush;
    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b0, 32'h0,        6'b000010, 1, 0};
    vecs[1] = '{5'd0,  5'd0, 1'b0, 1'b1, 5'd0,  1'b0, 32'h0,        6'b110000, 0, 0};
    vecs[2] = '{5'd5,  5'd0, 1'b0, 1'b0, 5'd5,  1'b0, 32'h0,        6'b110000, 0, 0};
    vecs[3] = '{5'd3,  5'd7, 1'b1, 1'b1, 5'd7,  1'b0, 32'h0,        6'b000010, 1, 0};
    vecs[4] = '{5'd3,  5'd7, 1'b0, 1'b1, 5'd7,  1'b0, 32'h0,        6'b110000, 0, 0};
    vecs[5] = '{5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b1, 32'h40,       6'b111111, 0, 1};
    vecs[6] = '{5'd1,  5'd2, 1'b1, 1'b0, 5'd9,  1'b1, 32'hDEADBEEF, 6'b111111, 0, 1};
    vecs[7] = '{5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 32'h0,        6'b000010, 1, 0};

    rst          = 1'b1;
    bus.dbg_halt = 1'b0;
    bus.dbg_step = 1'b0;
    bus.cnt_clr  = 1'b0;
    clear_hazards();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_stall",  32'(bus.stall_cnt), 32'd0);
    chk("rst_flush",  32'(bus.flush_cnt), 32'd0);
    chk("rst_ctl",    32'(ctl_now()), 32'(6'b110000));

    // Table-driven hazard decode in RUN
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 8; i++) begin
      bus.ID_RS      = vecs[i].rs;
      bus.ID_RT      = vecs[i].rt;
      bus.ID_use_rt  = vecs[i].use_rt;
      bus.DX_MemRead = vecs[i].memread;
      bus.DX_RD      = vecs[i].rd;
      bus.XM_branch  = vecs[i].br;
      bus.XM_BT      = vecs[i].bt;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_target", i), bus.PC_target, vecs[i].bt);
      tick();
      exp_stall += vecs[i].st_inc;
      exp_flush += vecs[i].fl_inc;
      chk($sformatf("vec%0d_stall_cnt", i), 32'(bus.stall_cnt), 32'(exp_stall));
      chk($sformatf("vec%0d_flush_cnt", i), 32'(bus.flush_cnt), 32'(exp_flush));
      clear_hazards();
    end

    // Reset mid-DRAIN (count 2) returns to RUN and clears counters
    bus.dbg_halt = 1'b1;
    tick();
    tick();
    chk("drain_pcw", 32'(bus.PC_write), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_held_ctl", 32'(ctl_now()), 32'(6'b110000));
    tick();
    rst          = 1'b0;
    bus.dbg_halt = 1'b0;
    #1;
    chk("midrst_halted", 32'(bus.halted), 32'd0);
    chk("midrst_stall",  32'(bus.stall_cnt), 32'd0);
    chk("midrst_flush",  32'(bus.flush_cnt), 32'd0);
    tick();
    chk("midrst_run_ctl", 32'(ctl_now()), 32'(6'b110000));

    // Halt: halted rises exactly 5 edges after dbg_halt is first sampled
    bus.dbg_halt = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("halt_e%0d_halted", e), 32'(bus.halted), (e == 5) ? 32'd1 : 32'd0);
      chk($sformatf("halt_e%0d_pcw", e), 32'(bus.PC_write), 32'd0);
    end

    // Single step: one fetch cycle, four drain cycles, then halted again
    bus.dbg_step = 1'b1;
    tick();
    bus.dbg_step = 1'b0;
    #1;
    chk("step_pcw",    32'(bus.PC_write), 32'd1);
    chk("step_iflush", 32'(bus.IF_flush), 32'd0);
    chk("step_halted", 32'(bus.halted), 32'd0);
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk($sformatf("stepdrain%0d_pcw", d), 32'(bus.PC_write), 32'd0);
      chk($sformatf("stepdrain%0d_iflush", d), 32'(bus.IF_flush), 32'd1);
      chk($sformatf("stepdrain%0d_halted", d), 32'(bus.halted), 32'd0);
    end
    tick();
    chk("step_rehalt", 32'(bus.halted), 32'd1);
    bus.dbg_halt = 1'b0;
    tick();
    chk("resume_halted", 32'(bus.halted), 32'd0);
    chk("resume_ctl", 32'(ctl_now()), 32'(6'b110000));

    // Load-use during DRAIN holds the drain count for that cycle
    bus.dbg_halt = 1'b1;
    tick();
    bus.DX_MemRead = 1'b1;
    bus.DX_RD      = 5'd5;
    bus.ID_RS      = 5'd5;
    #1;
    chk("drain_lu_ctl", 32'(ctl_now()), 32'(6'b000010));
    tick();
    clear_hazards();
    tick();
    tick();
    tick();
    chk("drain_lu_not_yet", 32'(bus.halted), 32'd0);
    tick();
    chk("drain_lu_halted", 32'(bus.halted), 32'd1);
    bus.dbg_halt = 1'b0;
    tick();

    // Counter saturation and clear priority
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    #1;
    chk("clr_stall", 32'(bus.stall_cnt), 32'd0);
    bus.DX_MemRead = 1'b1;
    bus.DX_RD      = 5'd9;
    bus.ID_RS      = 5'd9;
    for (int s = 0; s < 20; s++) tick();
    chk("sat_stall", 32'(bus.stall_cnt), 32'd15);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    clear_hazards();
    #1;
    chk("clr_wins_stall", 32'(bus.stall_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
